// File: rtl/gpio_seq_pkg.sv
// Shared types and parameter defaults for the GPIO sequence checker.
package gpio_seq_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_TMO_W  = 16;
  localparam int unsigned DEF_STABLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT      = 2'd1,
    ST_DONE_PASS = 2'd2,
    ST_DONE_FAIL = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_seq_table.sv
// Sequence table: DEPTH entries of {resp_en, resp, expect}, one write port,
// one asynchronous read port. No reset so contents survive a block reset.
module gpio_seq_table
  import gpio_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wexpect_i,
  input  logic [WIDTH-1:0] wresp_i,
  input  logic             wresp_en_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rexpect_o,
  output logic [WIDTH-1:0] rresp_o,
  output logic             rresp_en_o
);

  logic [2*WIDTH:0] mem_q [DEPTH];
  logic [2*WIDTH:0] entry;

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= {wresp_en_i, wresp_i, wexpect_i};
    end
  end

  // Asynchronous read port, split into fields
  always_comb begin
    entry      = mem_q[raddr_i];
    rexpect_o  = entry[WIDTH-1:0];
    rresp_o    = entry[2*WIDTH-1:WIDTH];
    rresp_en_o = entry[2*WIDTH];
  end

endmodule

// File: rtl/gpio_seq_checker.sv
// GPIO sequence checker: walks a table of expected input patterns, confirms
// each after STABLE matching cycles, drives an optional response per step and
// flags pass/fail (with per-step timeout).
module gpio_seq_checker
  import gpio_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned TMO_W  = DEF_TMO_W,
  parameter int unsigned STABLE = DEF_STABLE,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [WIDTH-1:0] tbl_expect,
  input  logic [WIDTH-1:0] tbl_resp,
  input  logic             tbl_resp_en,
  input  logic [AW:0]      num_steps,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             gpio_oe,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [AW:0]      step_idx,
  output logic [AW:0]      fail_step
);

  localparam int unsigned SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] STABLE_C = SW'(STABLE);

  state_e           state_q;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [SW-1:0]    stable_q, stable_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_limit_q;
  logic [AW:0]      num_steps_q;
  logic [AW:0]      step_idx_q, step_idx_d;
  logic [AW:0]      fail_step_q;
  logic [WIDTH-1:0] gpio_out_q;
  logic             gpio_oe_q, busy_q, pass_q, fail_q;

  logic             tbl_we_eff;
  logic [WIDTH-1:0] cur_expect, cur_resp;
  logic             cur_resp_en;
  logic             match, confirm, timeout;

  // Table writes are locked out while a run is in progress
  assign tbl_we_eff = tbl_we && (state_q != ST_WAIT);

  gpio_seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i      (clock),
    .we_i       (tbl_we_eff),
    .waddr_i    (tbl_addr),
    .wexpect_i  (tbl_expect),
    .wresp_i    (tbl_resp),
    .wresp_en_i (tbl_resp_en),
    .raddr_i    (step_idx_q[AW-1:0]),
    .rexpect_o  (cur_expect),
    .rresp_o    (cur_resp),
    .rresp_en_o (cur_resp_en)
  );

  // Two-flop synchronizer for the asynchronous GPIO input
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-cycle match, confirmation and saturating timeout evaluation
  always_comb begin
    match      = (sync2_q == cur_expect);
    stable_d   = match ? stable_q + 1'b1 : '0;
    confirm    = match && (stable_d == STABLE_C);
    tmo_d      = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
    timeout    = (tmo_limit_q != '0) && (tmo_d >= tmo_limit_q);
    step_idx_d = step_idx_q + 1'b1;
  end

  // Sequencer FSM with registered status and GPIO outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stable_q    <= '0;
      tmo_q       <= '0;
      tmo_limit_q <= '0;
      num_steps_q <= '0;
      step_idx_q  <= '0;
      fail_step_q <= '0;
      gpio_out_q  <= '0;
      gpio_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (confirm) begin
            // Confirmation takes priority over a coincident timeout
            if (cur_resp_en) begin
              gpio_out_q <= cur_resp;
              gpio_oe_q  <= 1'b1;
            end
            step_idx_q <= step_idx_d;
            stable_q   <= '0;
            tmo_q      <= '0;
            if (step_idx_d == num_steps_q) begin
              state_q <= ST_DONE_PASS;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end
          end else begin
            stable_q <= stable_d;
            if (tmo_limit_q != '0) begin
              if (timeout) begin
                state_q     <= ST_DONE_FAIL;
                busy_q      <= 1'b0;
                fail_q      <= 1'b1;
                fail_step_q <= step_idx_q;
              end else begin
                tmo_q <= tmo_d;
              end
            end
          end
        end
        default: begin
          // IDLE and both DONE states arm identically; GPIO drive is kept
          if (start) begin
            num_steps_q <= num_steps;
            tmo_limit_q <= tmo_limit;
            step_idx_q  <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            fail_q      <= 1'b0;
            fail_step_q <= '0;
            if (num_steps == '0) begin
              state_q <= ST_DONE_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              busy_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign gpio_out  = gpio_out_q;
  assign gpio_oe   = gpio_oe_q;
  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign step_idx  = step_idx_q;
  assign fail_step = fail_step_q;

endmodule
